// File: rtl/spi_reg_bank_pkg.sv
// Shared constants for the SPI register bank: register addresses, IRQ bit positions,
// CTRL bit positions and the default ID value.
package spi_reg_bank_pkg;

  // Register addresses
  localparam int unsigned ADDR_CTRL       = 0;
  localparam int unsigned ADDR_SCRATCH0   = 1;
  localparam int unsigned ADDR_SCRATCH1   = 2;
  localparam int unsigned ADDR_IRQ_STATUS = 3;
  localparam int unsigned ADDR_IRQ_MASK   = 4;
  localparam int unsigned ADDR_WR_COUNT   = 5;
  localparam int unsigned ADDR_ID         = 6;
  localparam int unsigned ADDR_CHECKSUM   = 7;

  // IRQ_STATUS / IRQ_MASK bit positions
  localparam int unsigned IRQ_WR_DONE = 0;
  localparam int unsigned IRQ_RO_ERR  = 1;
  localparam int unsigned IRQ_CNT_OVF = 2;
  localparam int unsigned IRQ_EXT     = 3;
  localparam int unsigned IRQ_NUM     = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_CLR    = 7;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_bank_if.sv
// Bus between spi_peripheral (master) and spi_reg_bank (slave).
interface spi_reg_bank_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned REG_W  = 8
);
  logic              ena;
  logic              wr_rdn;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic              we;
  logic              ext_evt;
  logic [REG_W-1:0]  rdata;
  logic [7:0]        status;
  logic              irq;

  modport master (
    output ena, wr_rdn, addr, wdata, we, ext_evt,
    input  rdata, status, irq
  );

  modport slave (
    input  ena, wr_rdn, addr, wdata, we, ext_evt,
    output rdata, status, irq
  );
endinterface

// File: rtl/spi_reg_bank_irq.sv
// Interrupt block: sticky IRQ_STATUS with W1C, IRQ_MASK, ext_evt edge detector and
// the registered irq output.
module spi_reg_bank_irq
  import spi_reg_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               i_ena,
  input  logic               i_wr_done,
  input  logic               i_ro_err,
  input  logic               i_cnt_ovf,
  input  logic               i_ext_evt,
  input  logic               i_w1c,
  input  logic [IRQ_NUM-1:0] i_w1c_data,
  input  logic               i_mask_we,
  input  logic [IRQ_NUM-1:0] i_mask_data,
  input  logic               i_irq_en,
  output logic [IRQ_NUM-1:0] o_irq_status,
  output logic [IRQ_NUM-1:0] o_irq_mask,
  output logic               o_irq,
  output logic               o_irq_d
);

  logic               r_ext_q;
  logic [IRQ_NUM-1:0] r_irq_status;
  logic [IRQ_NUM-1:0] r_irq_mask;
  logic               r_irq;
  logic [IRQ_NUM-1:0] w_events;
  logic [IRQ_NUM-1:0] w_status_d;
  logic               w_irq_d;

  // Collect hardware set events and build next status; a set beats a same-cycle W1C
  always_comb begin
    w_events              = '0;
    w_events[IRQ_WR_DONE] = i_wr_done;
    w_events[IRQ_RO_ERR]  = i_ro_err;
    w_events[IRQ_CNT_OVF] = i_cnt_ovf;
    w_events[IRQ_EXT]     = i_ext_evt & ~r_ext_q;
    w_status_d            = (r_irq_status & ~(i_w1c ? i_w1c_data : '0)) | w_events;
    // Uses pre-edge register values, so irq lags a status change by one cycle
    w_irq_d               = i_irq_en & (|(r_irq_status & r_irq_mask));
  end

  // Status, mask, edge-detect flop and irq register
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_ext_q      <= 1'b0;
      r_irq_status <= '0;
      r_irq_mask   <= '0;
      r_irq        <= 1'b0;
    end else if (i_ena) begin
      r_ext_q      <= i_ext_evt;
      r_irq_status <= w_status_d;
      if (i_mask_we) begin
        r_irq_mask <= i_mask_data;
      end
      r_irq        <= w_irq_d;
    end
  end

  assign o_irq_status = r_irq_status;
  assign o_irq_mask   = r_irq_mask;
  assign o_irq        = r_irq;
  assign o_irq_d      = w_irq_d;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind spi_peripheral: CTRL, scratch, write counter, checksum, ID,
// registered read mux and status byte. Interrupt registers live in spi_reg_bank_irq.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned REG_W    = 8,
  parameter logic [7:0]  ID_VALUE = ID_DEFAULT
) (
  input logic            clk,
  input logic            rstb,
  spi_reg_bank_if.slave  bus
);

  logic [6:0]         r_ctrl;  // CLR bit is never stored
  logic [REG_W-1:0]   r_scratch0;
  logic [REG_W-1:0]   r_scratch1;
  logic [REG_W-1:0]   r_wr_count;
  logic [REG_W-1:0]   r_checksum;
  logic [REG_W-1:0]   r_rdata;
  logic [7:0]         r_status;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_wr;
  logic               w_ro;
  logic               w_rw;
  logic               w_clr;
  logic               w_cnt_ovf;
  logic [REG_W-1:0]   w_rdata;
  logic [IRQ_NUM-1:0] w_irq_status;
  logic [IRQ_NUM-1:0] w_irq_mask;
  logic               w_irq;
  logic               w_irq_d;

  assign w_addr = bus.addr;

  // Decode accepted writes into register-bank events
  always_comb begin
    w_wr      = bus.we & bus.wr_rdn & bus.ena;
    w_ro      = w_wr & (w_addr > ADDR_W'(ADDR_IRQ_MASK));
    w_rw      = w_wr & ~w_ro;
    w_clr     = w_rw & (w_addr == ADDR_W'(ADDR_CTRL)) & bus.wdata[CTRL_CLR];
    // A clearing write resets the counter, so it never counts as a wrap
    w_cnt_ovf = w_rw & ~w_clr & (r_wr_count == '1);
  end

  // Read mux from the current address
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_W'(ADDR_CTRL):       w_rdata = REG_W'({1'b0, r_ctrl});
      ADDR_W'(ADDR_SCRATCH0):   w_rdata = r_scratch0;
      ADDR_W'(ADDR_SCRATCH1):   w_rdata = r_scratch1;
      ADDR_W'(ADDR_IRQ_STATUS): w_rdata = REG_W'(w_irq_status);
      ADDR_W'(ADDR_IRQ_MASK):   w_rdata = REG_W'(w_irq_mask);
      ADDR_W'(ADDR_WR_COUNT):   w_rdata = r_wr_count;
      ADDR_W'(ADDR_ID):         w_rdata = REG_W'(ID_VALUE);
      ADDR_W'(ADDR_CHECKSUM):   w_rdata = r_checksum;
      default:                  w_rdata = '0;
    endcase
  end

  // Writable registers, counter/checksum, read data and status packing
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_ctrl     <= '0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_wr_count <= '0;
      r_checksum <= '0;
      r_rdata    <= '0;
      r_status   <= '0;
    end else if (bus.ena) begin
      if (w_rw && (w_addr == ADDR_W'(ADDR_CTRL)))     r_ctrl     <= bus.wdata[6:0];
      if (w_rw && (w_addr == ADDR_W'(ADDR_SCRATCH0))) r_scratch0 <= bus.wdata;
      if (w_rw && (w_addr == ADDR_W'(ADDR_SCRATCH1))) r_scratch1 <= bus.wdata;
      if (w_clr) begin
        r_wr_count <= '0;
        r_checksum <= '0;
      end else if (w_rw) begin
        r_wr_count <= r_wr_count + REG_W'(1);
        r_checksum <= r_checksum ^ bus.wdata;
      end
      r_rdata  <= w_rdata;
      // Bit 7 takes the same next value as irq so the two always agree
      r_status <= {w_irq_d, 3'b000, w_irq_status};
    end
  end

  spi_reg_bank_irq u_irq (
    .clk          (clk),
    .rstb         (rstb),
    .i_ena        (bus.ena),
    .i_wr_done    (w_wr),
    .i_ro_err     (w_ro),
    .i_cnt_ovf    (w_cnt_ovf),
    .i_ext_evt    (bus.ext_evt),
    .i_w1c        (w_rw & (w_addr == ADDR_W'(ADDR_IRQ_STATUS))),
    .i_w1c_data   (bus.wdata[IRQ_NUM-1:0]),
    .i_mask_we    (w_rw & (w_addr == ADDR_W'(ADDR_IRQ_MASK))),
    .i_mask_data  (bus.wdata[IRQ_NUM-1:0]),
    .i_irq_en     (r_ctrl[CTRL_IRQ_EN]),
    .o_irq_status (w_irq_status),
    .o_irq_mask   (w_irq_mask),
    .o_irq        (w_irq),
    .o_irq_d      (w_irq_d)
  );

  assign bus.rdata  = r_rdata;
  assign bus.status = r_status;
  assign bus.irq    = w_irq;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank.
module tb_spi_reg_bank;

  logic clk;
  logic rstb;
  int   n_checks;
  int   n_fails;

  spi_reg_bank_if #(.ADDR_W(3), .REG_W(8)) bus ();

  spi_reg_bank #(.ADDR_W(3), .REG_W(8), .ID_VALUE(8'hA5)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    bus.addr   = a;
    bus.wdata  = d;
    bus.we     = 1'b1;
    bus.wr_rdn = 1'b1;
    tick();
    bus.we     = 1'b0;
    bus.wr_rdn = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    bus.addr = a;
    tick();
    tick();
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rstb = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.rdata !== 8'h00) begin
      n_fails++; $display("FAIL reset_rdata: got %h want %h", bus.rdata, 8'h00);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fails++; $display("FAIL reset_irq: got %b want %b", bus.irq, 1'b0);
    end
    n_checks++;
    if (bus.status !== 8'h00) begin
      n_fails++; $display("FAIL reset_status: got %h want %h", bus.status, 8'h00);
    end
    rstb = 1'b1;
    read_reg(3'd6, v);
    n_checks++;
    if (v !== 8'hA5) begin
      n_fails++; $display("FAIL reset_id: got %h want %h", v, 8'hA5);
    end
  endtask

  task automatic test_write_readback();
    logic [7:0] v;
    write_reg(3'd1, 8'h3C);
    write_reg(3'd2, 8'h5A);
    read_reg(3'd1, v);
    n_checks++;
    if (v !== 8'h3C) begin
      n_fails++; $display("FAIL wr_scratch0: got %h want %h", v, 8'h3C);
    end
    read_reg(3'd2, v);
    n_checks++;
    if (v !== 8'h5A) begin
      n_fails++; $display("FAIL wr_scratch1: got %h want %h", v, 8'h5A);
    end
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 8'h02) begin
      n_fails++; $display("FAIL wr_count: got %h want %h", v, 8'h02);
    end
    read_reg(3'd7, v);
    n_checks++;
    if (v !== 8'h66) begin
      n_fails++; $display("FAIL wr_checksum: got %h want %h", v, 8'h66);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h01) begin
      n_fails++; $display("FAIL wr_irq_status: got %h want %h", v, 8'h01);
    end
    n_checks++;
    if (bus.status !== 8'h01) begin
      n_fails++; $display("FAIL wr_status: got %h want %h", bus.status, 8'h01);
    end
  endtask

  task automatic test_ro_write();
    logic [7:0] v;
    write_reg(3'd6, 8'hFF);
    read_reg(3'd6, v);
    n_checks++;
    if (v !== 8'hA5) begin
      n_fails++; $display("FAIL ro_id: got %h want %h", v, 8'hA5);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h03) begin
      n_fails++; $display("FAIL ro_irq_status: got %h want %h", v, 8'h03);
    end
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 8'h02) begin
      n_fails++; $display("FAIL ro_count: got %h want %h", v, 8'h02);
    end
    read_reg(3'd7, v);
    n_checks++;
    if (v !== 8'h66) begin
      n_fails++; $display("FAIL ro_checksum: got %h want %h", v, 8'h66);
    end
  endtask

  task automatic test_irq();
    logic [7:0] v;
    write_reg(3'd3, 8'h0F);  // status -> 0x01
    write_reg(3'd4, 8'h08);
    write_reg(3'd0, 8'h01);
    tick();
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fails++; $display("FAIL irq_idle: got %b want %b", bus.irq, 1'b0);
    end
    bus.ext_evt = 1'b1;
    tick();
    bus.ext_evt = 1'b0;
    tick();
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fails++; $display("FAIL irq_ext: got %b want %b", bus.irq, 1'b1);
    end
    n_checks++;
    if (bus.status !== 8'h89) begin
      n_fails++; $display("FAIL irq_status_byte: got %h want %h", bus.status, 8'h89);
    end
    write_reg(3'd3, 8'h08);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fails++; $display("FAIL irq_lag: got %b want %b", bus.irq, 1'b1);
    end
    tick();
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fails++; $display("FAIL irq_w1c_drop: got %b want %b", bus.irq, 1'b0);
    end
    n_checks++;
    if (bus.status !== 8'h01) begin
      n_fails++; $display("FAIL irq_w1c_status: got %h want %h", bus.status, 8'h01);
    end
    // EXT set, then a W1C of EXT coincident with a fresh rising edge
    bus.ext_evt = 1'b1;
    tick();
    bus.ext_evt = 1'b0;
    tick();
    bus.ext_evt = 1'b1;
    write_reg(3'd3, 8'h08);
    bus.ext_evt = 1'b0;
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h09) begin
      n_fails++; $display("FAIL irq_set_wins: got %h want %h", v, 8'h09);
    end
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_fails++; $display("FAIL irq_set_wins_irq: got %b want %b", bus.irq, 1'b1);
    end
    // A level held high sets EXT only once
    write_reg(3'd3, 8'h0F);
    bus.ext_evt = 1'b1;
    tick();
    tick();
    write_reg(3'd3, 8'h08);
    tick();
    tick();
    read_reg(3'd3, v);
    bus.ext_evt = 1'b0;
    n_checks++;
    if (v !== 8'h01) begin
      n_fails++; $display("FAIL irq_level_held: got %h want %h", v, 8'h01);
    end
    n_checks++;
    if (bus.irq !== 1'b0) begin
      n_fails++; $display("FAIL irq_level_irq: got %b want %b", bus.irq, 1'b0);
    end
  endtask

  task automatic test_counter_wrap();
    logic [7:0] v;
    write_reg(3'd3, 8'h0F);
    write_reg(3'd0, 8'h81);  // clear count/checksum, keep irq enable
    for (int i = 0; i < 256; i++) begin
      write_reg(3'd1, 8'(i));
    end
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL wrap_count: got %h want %h", v, 8'h00);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h05) begin
      n_fails++; $display("FAIL wrap_ovf: got %h want %h", v, 8'h05);
    end
    read_reg(3'd1, v);
    n_checks++;
    if (v !== 8'hFF) begin
      n_fails++; $display("FAIL wrap_last_data: got %h want %h", v, 8'hFF);
    end
    write_reg(3'd2, 8'h11);
    read_reg(3'd7, v);
    n_checks++;
    if (v !== 8'h11) begin
      n_fails++; $display("FAIL wrap_checksum: got %h want %h", v, 8'h11);
    end
    write_reg(3'd0, 8'h80);
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL clr_count: got %h want %h", v, 8'h00);
    end
    read_reg(3'd7, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL clr_checksum: got %h want %h", v, 8'h00);
    end
    read_reg(3'd0, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL clr_ctrl: got %h want %h", v, 8'h00);
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] v;
    read_reg(3'd1, v);
    bus.ena    = 1'b0;
    bus.addr   = 3'd6;
    bus.wdata  = 8'h77;
    bus.we     = 1'b1;
    bus.wr_rdn = 1'b1;
    bus.ext_evt = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.rdata !== 8'hFF) begin
      n_fails++; $display("FAIL ena_rdata_hold: got %h want %h", bus.rdata, 8'hFF);
    end
    n_checks++;
    if (bus.status !== 8'h05) begin
      n_fails++; $display("FAIL ena_status_hold: got %h want %h", bus.status, 8'h05);
    end
    bus.addr    = 3'd1;
    tick();
    bus.we      = 1'b0;
    bus.wr_rdn  = 1'b0;
    bus.ext_evt = 1'b0;
    bus.ena     = 1'b1;
    read_reg(3'd1, v);
    n_checks++;
    if (v !== 8'hFF) begin
      n_fails++; $display("FAIL ena_scratch0: got %h want %h", v, 8'hFF);
    end
    read_reg(3'd5, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL ena_count: got %h want %h", v, 8'h00);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h05) begin
      n_fails++; $display("FAIL ena_irq_status: got %h want %h", v, 8'h05);
    end
    // Reset while a write is in flight
    bus.addr   = 3'd1;
    bus.wdata  = 8'h42;
    bus.we     = 1'b1;
    bus.wr_rdn = 1'b1;
    rstb       = 1'b0;
    tick();
    bus.we     = 1'b0;
    bus.wr_rdn = 1'b0;
    tick();
    rstb = 1'b1;
    n_checks++;
    if (bus.status !== 8'h00) begin
      n_fails++; $display("FAIL rst_status: got %h want %h", bus.status, 8'h00);
    end
    read_reg(3'd1, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL rst_scratch0: got %h want %h", v, 8'h00);
    end
    read_reg(3'd3, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL rst_irq_status: got %h want %h", v, 8'h00);
    end
    read_reg(3'd4, v);
    n_checks++;
    if (v !== 8'h00) begin
      n_fails++; $display("FAIL rst_irq_mask: got %h want %h", v, 8'h00);
    end
    read_reg(3'd6, v);
    n_checks++;
    if (v !== 8'hA5) begin
      n_fails++; $display("FAIL rst_id: got %h want %h", v, 8'hA5);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rstb        = 1'b0;
    bus.ena     = 1'b1;
    bus.we      = 1'b0;
    bus.wr_rdn  = 1'b0;
    bus.addr    = 3'd0;
    bus.wdata   = 8'h00;
    bus.ext_evt = 1'b0;
    test_reset();
    test_write_readback();
    test_ro_write();
    test_irq();
    test_counter_wrap();
    test_enable_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
